// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Runs one fixed-latency transaction at a time: ISSUE, WAIT for LAT cycles, then RESP.
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t             state_reg, state_next;
  logic               last_grant_reg;
  logic               id_reg;
  logic               we_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [3:0]         cnt_reg;
  logic [DATA_W-1:0]  rdata0_reg, rdata1_reg;
  logic               pick;

  // On a tie the port that did not win last time goes; a lone requester always wins.
  assign pick = (req0 && req1) ? ~last_grant_reg : req1;

  always_comb begin
    state_next = state_reg;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE:  if (req0 || req1) state_next = ISSUE;
      ISSUE: begin
        mem_en     = 1'b1;
        mem_we     = we_reg;
        gnt0       = ~id_reg;
        gnt1       = id_reg;
        state_next = WAIT;
      end
      WAIT:  if (cnt_reg == 4'd1) state_next = RESP;
      RESP: begin
        done0      = ~id_reg;
        done1      = id_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rdata0    = rdata0_reg;
  assign rdata1    = rdata1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            id_reg         <= pick;
            last_grant_reg <= pick;
            we_reg         <= pick ? we1 : we0;
            addr_reg       <= pick ? addr1 : addr0;
            wdata_reg      <= pick ? wdata1 : wdata0;
          end
        end
        ISSUE: cnt_reg <= LAT_CNT;
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          // Counter at 1 marks the cycle mem_rdata is valid.
          if (cnt_reg == 4'd1 && !we_reg) begin
            if (id_reg) rdata1_reg <= mem_rdata;
            else        rdata0_reg <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port data memory between two requesters: port 0 (processor load/store) and port 1 (debug/program loader).
- Uses a req/gnt/done handshake with round-robin priority.
- Sits between processor_top's memory stage and the data_mem instance.
- Runs a fixed-latency transaction sequencer, so requesters see a uniform completion pulse for both reads and writes.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, data width.
- LAT, 1, memory read latency in cycles, from the mem_en cycle to valid mem_rdata. Legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  transaction request, per port.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted and issued to memory.
- done0 / done1  out  1  one-cycle pulse: transaction complete.
- rdata0 / rdata1  out  DATA_W  read data, valid while the matching done is high.
- busy  out  1  high in every state except IDLE.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; only meaningful with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - The following are 0: wait counter, latched request registers, rdata0, rdata1, and all outputs (gnt*, done*, busy, mem_en, mem_we, mem_addr, mem_wdata).
  - Reset in any state aborts the transaction in flight: no gnt or done follows, and no further mem_en is issued.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req* are sampled only in this state.
  - If only one req is high, that port wins.
  - If both are high, the port != last_grant wins.
  - At the edge: latch the winner's id, we, addr and wdata; update last_grant; go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_we, mem_addr, mem_wdata driven from the latches.
  - gnt of the winner = 1.
  - Wait counter loads LAT; go to WAIT.
- WAIT:
  - Counter decrements each cycle. mem_en = 0; mem_addr and mem_wdata hold their latched values.
  - mem_rdata is valid in cycle ISSUE+LAT, which is the cycle in which counter == 1.
  - In that cycle: capture mem_rdata into the winner's rdata register (reads only), then go to RESP.
  - On a write, the rdata registers are unchanged.
- RESP (1 cycle): done of the winner = 1; go to IDLE.
- Latency: gnt arrives 1 cycle after req is sampled. done arrives LAT+1 cycles after gnt. With LAT=1: req sampled at T, gnt at T+1, done at T+3.
- Each rdataN holds its value until that port's next read completes.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt.
  - Drop req in the cycle after gnt, unless a new transaction is intended.
  - A req still high when the FSM returns to IDLE is a new transaction.
  - req changes during ISSUE, WAIT or RESP are ignored.
- Fairness: under continuous contention, grants alternate 0, 1, 0, 1. A lone requester wins every arbitration, regardless of last_grant.
- Only one transaction is in flight at a time; throughput is one per LAT+3 cycles.
- The counter is 4 bits wide; LAT=8 must not wrap.

Test Plan:
- LAT=1:
  - Stimulus: after reset, req0=1, we0=0, addr0=0x005, memory[5]=0xDEADBEEF.
  - Required: gnt0 one cycle later with mem_en=1, mem_addr=0x005; done0 2 cycles after gnt0 with rdata0=0xDEADBEEF; busy high for exactly 3 cycles.
- Contention:
  - Stimulus: req0 and req1 both held high for 4 transactions from reset.
  - Required: grant order 0, 1, 0, 1; gnt0 and gnt1 never high together; done0 and done1 never high together.
- Write-then-read:
  - Stimulus: port 1 writes 0x12345678 to addr 0x3FF, then port 0 reads addr 0x3FF.
  - Required: mem_we=1 only in port 1's ISSUE cycle; done1 pulses with rdata1 unchanged; then rdata0=0x12345678 at done0.
- LAT=3:
  - Stimulus: a single read.
  - Required: done exactly 4 cycles after gnt; mem_en high for exactly 1 cycle.
- Reset mid-operation:
  - Stimulus: rst asserted during the WAIT state of a port 0 read.
  - Required: no done0 pulse; busy=0 and mem_en=0 the cycle after reset; the next req1 is granted normally, and a later tie goes to port 0.
- Held request:
  - Stimulus: req0 kept high through done0, with req1=0.
  - Required: a second port 0 transaction starts immediately (gnt0 again 2 cycles after done0).
